// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the CPU pipeline and one
// 8-bit synchronous RAM port. It arbitrates instruction fetches (IF) against
// loads/stores (MEM), splits each access into byte transfers and returns
// zero-extended little-endian words. Stall is requested while any access
// is outstanding.
`timescale 1ns/1ps
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        stall_req,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic [31:0] base;       // latched start address of the access
  logic [31:0] wbuf;       // latched store data
  logic [31:0] rbuf;       // read assembly buffer, unused bytes stay zero
  logic [2:0]  n_bytes;    // access size in bytes: 1, 2 or 4
  logic [2:0]  cnt;        // clock edges elapsed since the request was accepted
  logic        owner_mem;  // 1 = access belongs to MEM stage, 0 = IF stage

  logic [2:0]  n_sel;      // decoded size of the pending MEM request
  logic [2:0]  step;       // index of the edge about to be taken (cnt + 1)
  logic [2:0]  cap_idx;    // byte lane captured from ram_din on this edge
  logic [31:0] step_addr;  // base + step, wraps modulo 2^32
  logic [7:0]  step_wbyte; // store byte issued on this edge
  logic [31:0] rbuf_merged;// read buffer with the arriving byte inserted

  // Stall the pipeline while either requester still waits for its done pulse.
  assign stall_req = (mem_req & ~mem_done) | (if_req & ~if_done);

  // Decode the MEM transfer size; 10 and 11 both mean a full word.
  always_comb begin
    n_sel = 3'd4;
    case (mem_len)
      2'b00:   n_sel = 3'd1;
      2'b01:   n_sel = 3'd2;
      default: n_sel = 3'd4;
    endcase
  end

  // Per-edge byte lane selection for address, store data and read capture.
  // A read byte addressed after edge k arrives on ram_din one cycle later and
  // is sampled on edge k+2, hence the capture lane trails the step by two.
  always_comb begin
    step      = cnt + 3'd1;
    cap_idx   = step - 3'd2;
    step_addr = base + {29'd0, step};

    step_wbyte = wbuf[7:0];
    case (step)
      3'd1:    step_wbyte = wbuf[15:8];
      3'd2:    step_wbyte = wbuf[23:16];
      3'd3:    step_wbyte = wbuf[31:24];
      default: step_wbyte = wbuf[7:0];
    endcase

    rbuf_merged = rbuf;
    case (cap_idx)
      3'd0:    rbuf_merged[7:0]   = ram_din;
      3'd1:    rbuf_merged[15:8]  = ram_din;
      3'd2:    rbuf_merged[23:16] = ram_din;
      3'd3:    rbuf_merged[31:24] = ram_din;
      default: rbuf_merged = rbuf;
    endcase
  end

  // Access FSM: arbitration, byte sequencing, RAM port and completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= 32'd0;
      wbuf      <= 32'd0;
      rbuf      <= 32'd0;
      n_bytes   <= 3'd4;
      cnt       <= 3'd0;
      owner_mem <= 1'b0;
      ram_a     <= 32'd0;
      ram_dout  <= 8'd0;
      ram_wr    <= 1'b0;
      if_data   <= 32'd0;
      if_done   <= 1'b0;
      mem_rdata <= 32'd0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          ram_wr <= 1'b0;
          // MEM wins: its instruction is older than the one being fetched.
          if (mem_req) begin
            base      <= mem_addr;
            wbuf      <= mem_wdata;
            n_bytes   <= n_sel;
            owner_mem <= 1'b1;
            cnt       <= 3'd0;
            rbuf      <= 32'd0;
            ram_a     <= mem_addr;
            if (mem_we) begin
              ram_dout <= mem_wdata[7:0];
              ram_wr   <= 1'b1;
              state    <= WR;
            end else begin
              state <= RD;
            end
          end else if (if_req) begin
            base      <= if_addr;
            n_bytes   <= 3'd4;
            owner_mem <= 1'b0;
            cnt       <= 3'd0;
            rbuf      <= 32'd0;
            ram_a     <= if_addr;
            state     <= RD;
          end
        end

        RD: begin
          cnt <= step;
          if (step < n_bytes) begin
            ram_a <= step_addr;
          end
          if (step >= 3'd2) begin
            rbuf <= rbuf_merged;
          end
          if (step == n_bytes + 3'd1) begin
            state <= DONE;
            if (owner_mem) begin
              mem_rdata <= rbuf_merged;
              mem_done  <= 1'b1;
            end else begin
              if_data <= rbuf_merged;
              if_done <= 1'b1;
            end
          end
        end

        WR: begin
          cnt <= step;
          if (step < n_bytes) begin
            ram_a    <= step_addr;
            ram_dout <= step_wbyte;
            ram_wr   <= 1'b1;
          end else begin
            ram_wr   <= 1'b0;
            state    <= DONE;
            mem_done <= 1'b1;
          end
        end

        DONE: begin
          // Requests are ignored here so the requester can drop req in time.
          ram_wr <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          ram_wr <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a transaction-level
// reference model, a RAM model, directed scenarios and randomized traffic
// from two concurrent requesters.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'b00;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall_req;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = 8'd0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_req(stall_req),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Unwritten RAM locations hold an address-derived pattern.
  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  logic [7:0] phys    [logic [31:0]];  // RAM seen by the DUT
  logic [7:0] ref_mem [logic [31:0]];  // model's view of RAM

  function automatic logic [7:0] phys_rd(input logic [31:0] a);
    if (phys.exists(a)) return phys[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  // Synchronous RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    ram_din <= phys_rd(ram_a);
    if (ram_wr) phys[ram_a] = ram_dout;
  end

  // ---------------- reference model ----------------
  // One access in flight; c counts edges since acceptance. A read of n bytes
  // completes n+1 edges after acceptance, a store n edges after; one more
  // edge returns to idle, and only then can a new request be taken.
  bit          m_busy = 0;
  bit          m_mem = 0;
  bit          m_we = 0;
  int          m_n = 0;
  int          m_L = 0;
  int          m_c = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_wdata = 0;
  logic [31:0] m_exp = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (m_we && m_c < m_n) ref_mem[m_addr + m_c] = 8'(m_wdata >> (8 * m_c));
      m_c++;
      if (m_c == m_L + 1) m_busy = 0;
    end else if (mem_req || if_req) begin
      m_busy  = 1;
      m_c     = 0;
      m_mem   = mem_req;
      m_we    = mem_req && mem_we;
      m_n     = !mem_req ? 4 : (mem_len == 2'b00) ? 1 : (mem_len == 2'b01) ? 2 : 4;
      m_addr  = mem_req ? mem_addr : if_addr;
      m_wdata = mem_wdata;
      m_L     = m_we ? m_n : m_n + 1;
      m_exp   = 32'd0;
      if (!m_we)
        for (int i = 0; i < m_n; i++) m_exp |= 32'(ref_rd(m_addr + i)) << (8 * i);
    end
  end

  // Compare DUT outputs with the model on every cycle, away from the clock edge.
  always @(negedge clk) begin
    bit e_md, e_id, e_wr;
    if (!rst) begin
      chk("rst_mem_done",  {31'd0, mem_done}, 32'd0);
      chk("rst_if_done",   {31'd0, if_done},  32'd0);
      chk("rst_ram_wr",    {31'd0, ram_wr},   32'd0);
      chk("rst_ram_a",     ram_a,             32'd0);
      chk("rst_ram_dout",  {24'd0, ram_dout}, 32'd0);
      chk("rst_mem_rdata", mem_rdata,         32'd0);
      chk("rst_if_data",   if_data,           32'd0);
    end else begin
      e_md = m_busy && m_mem && (m_c == m_L);
      e_id = m_busy && !m_mem && (m_c == m_L);
      e_wr = m_busy && m_we && (m_c < m_n);
      chk("mem_done", {31'd0, mem_done}, {31'd0, e_md});
      chk("if_done",  {31'd0, if_done},  {31'd0, e_id});
      chk("ram_wr",   {31'd0, ram_wr},   {31'd0, e_wr});
      chk("stall_req", {31'd0, stall_req},
          {31'd0, (mem_req & ~e_md) | (if_req & ~e_id)});
      if (m_busy && m_c < m_n) chk("ram_a", ram_a, m_addr + m_c);
      if (e_wr) chk("ram_dout", {24'd0, ram_dout}, {24'd0, 8'(m_wdata >> (8 * m_c))});
      if (e_md && !m_we) chk("mem_rdata", mem_rdata, m_exp);
      if (e_id) chk("if_data", if_data, m_exp);
    end
  end

  // ---------------- requester drivers ----------------
  logic [40:0] mem_trace [0:7];  // {ram_wr, ram_dout, ram_a} after each edge
  logic [31:0] if_trace  [0:7];
  logic        mem_stall_at_done;

  task automatic mem_access(input logic we, input logic [1:0] len, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd, output int cyc);
    bit got;
    mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
    cyc = 0; rd = 32'd0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (cyc < 8) mem_trace[cyc] = {ram_wr, ram_dout, ram_a};
      cyc++;
      if (mem_done) begin
        got = 1;
        rd = mem_rdata;
        mem_stall_at_done = stall_req;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL mem_timeout got no mem_done expected done within 40 cycles");
    end
    mem_req = 1'b0;
  endtask

  task automatic if_access(input logic [31:0] a, output logic [31:0] rd, output int cyc);
    bit got;
    if_addr = a; if_req = 1'b1; cyc = 0; rd = 32'd0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (cyc < 8) if_trace[cyc] = ram_a;
      cyc++;
      if (if_done) begin
        got = 1;
        rd = if_data;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL if_timeout got no if_done expected done within 40 cycles");
    end
    if_req = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + $urandom_range(0, 3);
    return 32'h0000_4000 + $urandom_range(0, 31);
  endfunction

  function automatic void preload(input logic [31:0] a, input logic [7:0] v);
    phys[a] = v;
    ref_mem[a] = v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected completion before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd2;
    int cyc, cyc2;

    // Reset
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ram_a", ram_a, 32'd0);
    chk("reset_ram_wr", {31'd0, ram_wr}, 32'd0);
    rst = 1'b1;
    settle();

    // Word load from 0x1000
    preload(32'h1000, 8'h11); preload(32'h1001, 8'h22);
    preload(32'h1002, 8'h33); preload(32'h1003, 8'h44);
    preload(32'h30, 8'h80);
    mem_access(1'b0, 2'b10, 32'h1000, 32'd0, rd, cyc);
    chk("word_load_data", rd, 32'h4433_2211);
    chk("word_load_cycles", cyc, 32'd6);
    chk("word_load_stall", {31'd0, mem_stall_at_done}, 32'd0);
    for (int k = 0; k < 4; k++) chk("word_load_ram_a", mem_trace[k][31:0], 32'h1000 + k);
    settle();

    // Simultaneous requests: MEM first, fetch after
    fork
      mem_access(1'b0, 2'b10, 32'h1000, 32'd0, rd, cyc);
      if_access(32'h1000, rd2, cyc2);
    join
    chk("arb_mem_cycles", cyc, 32'd6);
    chk("arb_if_cycles", cyc2, 32'd13);
    chk("arb_if_data", rd2, 32'h4433_2211);
    settle();

    // Half store of 0xABCD at 0x2002
    mem_access(1'b1, 2'b01, 32'h2002, 32'h0000_ABCD, rd, cyc);
    chk("half_store_cycles", cyc, 32'd3);
    chk("half_store_wr0", {31'd0, mem_trace[0][40]}, 32'd1);
    chk("half_store_a0", mem_trace[0][31:0], 32'h2002);
    chk("half_store_d0", {24'd0, mem_trace[0][39:32]}, 32'hCD);
    chk("half_store_wr1", {31'd0, mem_trace[1][40]}, 32'd1);
    chk("half_store_a1", mem_trace[1][31:0], 32'h2003);
    chk("half_store_d1", {24'd0, mem_trace[1][39:32]}, 32'hAB);
    chk("half_store_wr2", {31'd0, mem_trace[2][40]}, 32'd0);
    settle();
    chk("half_store_ram0", {24'd0, phys_rd(32'h2002)}, 32'hCD);
    chk("half_store_ram1", {24'd0, phys_rd(32'h2003)}, 32'hAB);

    // Byte load from 0x30
    mem_access(1'b0, 2'b00, 32'h30, 32'd0, rd, cyc);
    chk("byte_load_data", rd, 32'h0000_0080);
    chk("byte_load_cycles", cyc, 32'd3);
    settle();

    // Word fetch across the top of the address space
    if_access(32'hFFFF_FFFE, rd, cyc);
    chk("wrap_a0", if_trace[0], 32'hFFFF_FFFE);
    chk("wrap_a1", if_trace[1], 32'hFFFF_FFFF);
    chk("wrap_a2", if_trace[2], 32'h0000_0000);
    chk("wrap_a3", if_trace[3], 32'h0000_0001);
    chk("wrap_cycles", cyc, 32'd6);
    settle();

    // Reset in the middle of a word store
    mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h5000; mem_wdata = 32'hDEAD_BEEF;
    mem_req = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("midrst_wr_before", {31'd0, ram_wr}, 32'd1);
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    chk("midrst_wr_after", {31'd0, ram_wr}, 32'd0);
    chk("midrst_done", {31'd0, mem_done}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    chk("midrst_ram0", {24'd0, phys_rd(32'h5000)}, 32'hEF);
    chk("midrst_ram1", {24'd0, phys_rd(32'h5001)}, 32'hBE);
    chk("midrst_ram2", {24'd0, phys_rd(32'h5002)}, {24'd0, dflt(32'h5002)});
    chk("midrst_ram3", {24'd0, phys_rd(32'h5003)}, {24'd0, dflt(32'h5003)});
    @(posedge clk); #1;
    mem_access(1'b0, 2'b00, 32'h1000, 32'd0, rd, cyc);
    chk("post_rst_load", rd, 32'h0000_0011);
    chk("post_rst_cycles", cyc, 32'd3);
    settle();

    // Randomized traffic from both requesters
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [31:0] r;
          int c, g;
          g = $urandom_range(0, 3);
          repeat (g) begin @(posedge clk); #1; end
          mem_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_addr(),
                     $urandom, r, c);
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          logic [31:0] r;
          int c, g;
          g = $urandom_range(0, 4);
          repeat (g) begin @(posedge clk); #1; end
          if_access(rand_addr(), r, c);
        end
      end
    join
    settle();

    // RAM contents must match the model's image
    foreach (ref_mem[a]) chk("ram_image", {24'd0, phys_rd(a)}, {24'd0, ref_mem[a]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
